// File: rtl/ram_hs.sv
// ram_hs: single-port word RAM behind a valid/ready request channel and a
// valid/ready response channel. Every access is delayed by WAIT cycles to
// model slow memory. Writes are byte-enabled. Only one request is in flight.
// Optional feature macro: RAM_HS_ADDR_CHECK_EN. When it is defined, an
// out-of-range address is reported on resp_err. When it is not defined,
// resp_err is tied to 0.
module ram_hs #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1 << ADDR_W,
  parameter int WAIT   = 2,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // The address compare uses one extra bit, so DEPTH == 2**ADDR_W is handled.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_C  = 4'(WAIT);

  state_t              state_r;
  state_t              state_s;
  logic [3:0]          cnt_r;
  logic                wr_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   data_r;
  logic [BE_W-1:0]     be_r;
  logic                resp_valid_r;
  logic [DATA_W-1:0]   resp_data_r;
  logic                resp_err_r;
  logic                access_s;
  logic                in_range_s;
  logic                err_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic [DATA_W-1:0]   mem_r [0:DEPTH-1];

  assign in_range_s = ({1'b0, addr_r} < DEPTH_C);
  assign access_s   = (state_r == ST_WAIT) && (cnt_r == 4'd0);

`ifdef RAM_HS_ADDR_CHECK_EN
  assign err_s = ~in_range_s;
`else
  assign err_s = 1'b0;
`endif

  // State register. A reset abandons any access or response that is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode for the accept, wait, and respond sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) state_s = ST_WAIT;
        else           state_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) state_s = ST_RESP;
        else               state_s = ST_WAIT;
      end
      ST_RESP: begin
        if (resp_ready) state_s = ST_IDLE;
        else            state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Read word. Writes and out-of-range reads return zero.
  always_comb begin
    rd_word_s = {DATA_W{1'b0}};
    if (in_range_s && !wr_r) rd_word_s = mem_r[addr_r];
    else                     rd_word_s = {DATA_W{1'b0}};
  end

  // Request capture, the wait counter, and the registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r        <= 4'd0;
      wr_r         <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      data_r       <= {DATA_W{1'b0}};
      be_r         <= {BE_W{1'b0}};
      resp_valid_r <= 1'b0;
      resp_data_r  <= {DATA_W{1'b0}};
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            wr_r   <= req_wr;
            addr_r <= req_addr;
            data_r <= req_data;
            be_r   <= req_be;
            cnt_r  <= WAIT_C;
          end
        end
        ST_WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            resp_valid_r <= 1'b1;
            resp_data_r  <= rd_word_s;
            resp_err_r   <= err_s;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Memory array. It has no reset. Writes commit only at the end of the wait
  // phase, so a reset during the wait phase drops the write.
  always_ff @(posedge clk) begin
    if (access_s && wr_r && in_range_s) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_r[i]) mem_r[addr_r][8*i +: 8] <= data_r[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state_r == ST_IDLE);
  assign busy       = (state_r != ST_IDLE);
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_ram_hs.sv
// Testbench for ram_hs. Instance 0 uses DEPTH=1000 and WAIT=2 and is checked
// against a word-array reference model. Instances 1 and 2 use WAIT=0 and
// WAIT=15 and exercise the latency extremes.
module tb_ram_hs;

`ifdef RAM_HS_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int D0 = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_wr;
  logic [9:0]  req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_be;
  logic        req_valid  [3];
  logic        resp_ready [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic        resp_err   [3];
  logic        busy       [3];
  logic [31:0] resp_data  [3];

  int checks = 0;
  int errors = 0;

  logic [31:0] model [0:1023];
  bit          known [0:1023];

  always #5 clk = ~clk;

  ram_hs #(.DATA_W(32), .ADDR_W(10), .DEPTH(D0), .WAIT(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_data(resp_data[0]),
    .resp_err(resp_err[0]), .busy(busy[0]));

  ram_hs #(.DATA_W(32), .ADDR_W(10), .WAIT(0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_data(resp_data[1]),
    .resp_err(resp_err[1]), .busy(busy[1]));

  ram_hs #(.DATA_W(32), .ADDR_W(10), .WAIT(15)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_data(resp_data[2]),
    .resp_err(resp_err[2]), .busy(busy[2]));

  // Reference model: a byte-enable merge into a word array. Only in-range
  // addresses are stored.
  function automatic void model_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    if (int'(a) < D0) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
      if (be == 4'hF) known[a] = 1'b1;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [9:0] a);
    return (int'(a) < D0) ? model[a] : 32'h0;
  endfunction

  function automatic logic exp_err(input logic [9:0] a);
    return CHK && (int'(a) >= D0);
  endfunction

  // Runs one transaction on instance k with resp_ready held high. Called at
  // #1 after a rising edge. lat counts the clock edges from the accept edge to
  // the rise of resp_valid.
  task automatic xact(input int k, input logic wr, input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] be, output int lat, output logic [31:0] rd, output logic re);
    req_wr = wr; req_addr = a; req_data = d; req_be = be;
    req_valid[k] = 1'b1; resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    req_wr = 1'($urandom); req_addr = 10'($urandom); req_data = $urandom; req_be = 4'($urandom);
    lat = 0;
    while (!resp_valid[k] && lat <= 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_data[k];
    re = resp_err[k];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat; logic [31:0] rd; logic re;
    rst = 1'b1;
    #12;
    for (int k = 0; k < 3; k++) begin
      checks += 5;
      if (req_ready[k] !== 1'b1) begin errors++; $display("FAIL reset_req_ready[%0d] got %b exp 1", k, req_ready[k]); end
      if (resp_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_resp_valid[%0d] got %b exp 0", k, resp_valid[k]); end
      if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b exp 0", k, busy[k]); end
      if (resp_data[k] !== 32'h0) begin errors++; $display("FAIL reset_resp_data[%0d] got %h exp 0", k, resp_data[k]); end
      if (resp_err[k] !== 1'b0) begin errors++; $display("FAIL reset_resp_err[%0d] got %b exp 0", k, resp_err[k]); end
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    // Give addr 5 a known value, then reset during the wait of a later write.
    xact(0, 1'b1, 10'd5, 32'h0000_0000, 4'hF, lat, rd, re);
    model_write(10'd5, 32'h0000_0000, 4'hF);
    req_wr = 1'b1; req_addr = 10'd5; req_data = 32'hDEAD_BEEF; req_be = 4'hF; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL mid_wait_busy got %b exp 1", busy[0]); end
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL async_rst_busy got %b exp 0", busy[0]); end
    if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL async_rst_req_ready got %b exp 1", req_ready[0]); end
    if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL async_rst_resp_valid got %b exp 0", resp_valid[0]); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    xact(0, 1'b0, 10'd5, 32'h0, 4'h0, lat, rd, re);
    checks += 2;
    if (rd !== model_read(10'd5)) begin errors++; $display("FAIL dropped_write_read got %h exp %h", rd, model_read(10'd5)); end
    if (rd === 32'hDEAD_BEEF) begin errors++; $display("FAIL dropped_write_leak got %h must not be deadbeef", rd); end
  endtask

  task automatic test_basic();
    int lat; logic [31:0] rd; logic re;
    xact(0, 1'b1, 10'd3, 32'h1234_5678, 4'hF, lat, rd, re);
    model_write(10'd3, 32'h1234_5678, 4'hF);
    checks += 3;
    if (lat !== 3) begin errors++; $display("FAIL basic_wr_latency got %0d exp 3", lat); end
    if (rd !== 32'h0) begin errors++; $display("FAIL basic_wr_data got %h exp 0", rd); end
    if (re !== 1'b0) begin errors++; $display("FAIL basic_wr_err got %b exp 0", re); end
    xact(0, 1'b0, 10'd3, 32'hFFFF_FFFF, 4'hF, lat, rd, re);
    checks += 2;
    if (lat !== 3) begin errors++; $display("FAIL basic_rd_latency got %0d exp 3", lat); end
    if (rd !== 32'h1234_5678) begin errors++; $display("FAIL basic_rd_data got %h exp 12345678", rd); end
  endtask

  task automatic test_byte_en();
    int lat; logic [31:0] rd; logic re;
    xact(0, 1'b1, 10'd7, 32'hAABB_CCDD, 4'hF, lat, rd, re);
    model_write(10'd7, 32'hAABB_CCDD, 4'hF);
    xact(0, 1'b1, 10'd7, 32'h1122_3344, 4'b0101, lat, rd, re);
    model_write(10'd7, 32'h1122_3344, 4'b0101);
    xact(0, 1'b0, 10'd7, 32'h0, 4'h0, lat, rd, re);
    checks++;
    if (rd !== 32'hAA22_CC44) begin errors++; $display("FAIL byte_en_merge got %h exp aa22cc44", rd); end
    xact(0, 1'b1, 10'd7, 32'h5566_7788, 4'h0, lat, rd, re);
    model_write(10'd7, 32'h5566_7788, 4'h0);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL be0_wr_latency got %0d exp 3", lat); end
    xact(0, 1'b0, 10'd7, 32'h0, 4'h0, lat, rd, re);
    checks++;
    if (rd !== model_read(10'd7)) begin errors++; $display("FAIL be0_unchanged got %h exp %h", rd, model_read(10'd7)); end
  endtask

  task automatic test_backpressure();
    int lat;
    req_wr = 1'b0; req_addr = 10'd3; req_data = 32'h0; req_be = 4'h0;
    req_valid[0] = 1'b1; resp_ready[0] = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    lat = 0;
    while (!resp_valid[0] && lat <= 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL bp_latency got %0d exp 3", lat); end
    // Present a competing request while the response is stalled.
    req_wr = 1'b0; req_addr = 10'd7; req_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks += 3;
      if (resp_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc %0d got %b exp 1", c, resp_valid[0]); end
      if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_req_ready cyc %0d got %b exp 0", c, req_ready[0]); end
      if (resp_data[0] !== model_read(10'd3)) begin errors++; $display("FAIL bp_data_stable cyc %0d got %h exp %h", c, resp_data[0], model_read(10'd3)); end
    end
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    checks += 2;
    if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b exp 0", resp_valid[0]); end
    if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", req_ready[0]); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL bp_new_accept busy got %b exp 1", busy[0]); end
    lat = 0;
    while (!resp_valid[0] && lat <= 40) begin @(posedge clk); #1; lat++; end
    checks += 2;
    if (lat !== 3) begin errors++; $display("FAIL bp_new_latency got %0d exp 3", lat); end
    if (resp_data[0] !== model_read(10'd7)) begin errors++; $display("FAIL bp_new_data got %h exp %h", resp_data[0], model_read(10'd7)); end
    @(posedge clk); #1;
  endtask

  task automatic test_wait_lat();
    int lat; logic [31:0] rd; logic re; logic [31:0] d; logic [9:0] a; int exp_lat;
    for (int k = 1; k < 3; k++) begin
      exp_lat = (k == 1) ? 1 : 16;
      a = 10'($urandom);
      d = $urandom;
      xact(k, 1'b1, a, d, 4'hF, lat, rd, re);
      checks++;
      if (lat !== exp_lat) begin errors++; $display("FAIL wait_wr_latency[%0d] got %0d exp %0d", k, lat, exp_lat); end
      xact(k, 1'b0, a, 32'h0, 4'h0, lat, rd, re);
      checks += 3;
      if (lat !== exp_lat) begin errors++; $display("FAIL wait_rd_latency[%0d] got %0d exp %0d", k, lat, exp_lat); end
      if (rd !== d) begin errors++; $display("FAIL wait_rd_data[%0d] got %h exp %h", k, rd, d); end
      if (re !== 1'b0) begin errors++; $display("FAIL wait_rd_err[%0d] got %b exp 0", k, re); end
    end
  endtask

  task automatic test_addr_range();
    int lat; logic [31:0] rd; logic re;
    xact(0, 1'b1, 10'd1000, 32'hCAFE_F00D, 4'hF, lat, rd, re);
    checks += 2;
    if (re !== exp_err(10'd1000)) begin errors++; $display("FAIL oor_wr_err got %b exp %b", re, exp_err(10'd1000)); end
    if (rd !== 32'h0) begin errors++; $display("FAIL oor_wr_data got %h exp 0", rd); end
    xact(0, 1'b0, 10'd1000, 32'h0, 4'h0, lat, rd, re);
    checks += 2;
    if (re !== exp_err(10'd1000)) begin errors++; $display("FAIL oor_rd_err got %b exp %b", re, exp_err(10'd1000)); end
    if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_data got %h exp 0", rd); end
    checks++;
    if (resp_err[0] !== 1'b0) begin errors++; $display("FAIL oor_err_cleared got %b exp 0", resp_err[0]); end
    xact(0, 1'b1, 10'd999, 32'h0BAD_C0DE, 4'hF, lat, rd, re);
    model_write(10'd999, 32'h0BAD_C0DE, 4'hF);
    xact(0, 1'b0, 10'd999, 32'h0, 4'h0, lat, rd, re);
    checks += 2;
    if (re !== 1'b0) begin errors++; $display("FAIL edge_rd_err got %b exp 0", re); end
    if (rd !== 32'h0BAD_C0DE) begin errors++; $display("FAIL edge_rd_data got %h exp 0badc0de", rd); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; logic re; logic [9:0] a; logic [31:0] d; logic [3:0] be; logic wr;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) a = 10'($urandom_range(990, 1023));
      else                           a = 10'($urandom_range(0, 15));
      wr = 1'($urandom);
      d  = $urandom;
      be = 4'($urandom);
      xact(0, wr, a, d, be, lat, rd, re);
      checks += 2;
      if (lat !== 3) begin errors++; $display("FAIL rand_latency n=%0d got %0d exp 3", n, lat); end
      if (re !== exp_err(a)) begin errors++; $display("FAIL rand_err n=%0d addr %0d got %b exp %b", n, a, re, exp_err(a)); end
      if (wr) begin
        model_write(a, d, be);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL rand_wr_data n=%0d got %h exp 0", n, rd); end
      end else if (int'(a) >= D0 || known[a]) begin
        checks++;
        if (rd !== model_read(a)) begin errors++; $display("FAIL rand_rd_data n=%0d addr %0d got %h exp %h", n, a, rd, model_read(a)); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin model[i] = 32'h0; known[i] = 1'b0; end
    for (int k = 0; k < 3; k++) begin req_valid[k] = 1'b0; resp_ready[k] = 1'b1; end
    req_wr = 1'b0; req_addr = 10'h0; req_data = 32'h0; req_be = 4'h0;
    test_reset();
    test_basic();
    test_byte_en();
    test_backpressure();
    test_wait_lat();
    test_addr_range();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
